// File: rtl/uart_rx_byte_if.sv
// Receiver-side signal bundle for uart_rx_byte: serial line in, byte/strobes out.
// The slave modport is the receiver; the master modport is the line driver / byte consumer.
interface uart_rx_byte_if;
    logic       uart_rx;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic       framing_error;
    logic       parity_error;

    modport slave (
        input  uart_rx,
        output uart_data,
        output uart_data_valid,
        output framing_error,
        output parity_error
    );

    modport master (
        output uart_rx,
        input  uart_data,
        input  uart_data_valid,
        input  framing_error,
        input  parity_error
    );
endinterface

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 UART receiver with one-cycle byte strobe and error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_error strobe.
module uart_rx_byte #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_byte_if.slave  bus,
    output logic [2:0]     o_dbg_state
);
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cfg_check
        $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             w_fall;
    logic             w_bit_end;
    logic             w_half_end;
    logic             w_cnt_clr;
    logic             w_valid_nxt;
    logic             w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic             r_par_err;
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_bit_end  = (r_cnt == CNT_BIT_END);
    assign w_half_end = (r_cnt == CNT_HALF_END);

    // Synchronizer and edge-detect copy reset high so a released reset never looks like a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.uart_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE:  if (w_fall) w_next_state = S_START;
            S_START: if (w_half_end) w_next_state = r_rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (r_par_err) w_perr_nxt = 1'b1;
                        else
`endif
                        w_valid_nxt  = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_ferr_nxt   = 1'b1;
                        w_next_state = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: if (r_rx_s) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
        w_cnt_clr = (w_next_state != r_state) || (r_state == S_IDLE) ||
                    (r_state == S_WAIT_HIGH) || ((r_state == S_DATA) && w_bit_end);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift   <= {r_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_valid_nxt) r_data <= r_shift;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_par_err <= 1'b0;
            else if ((r_state == S_PARITY) && w_bit_end)
                r_par_err <= ^{r_shift, r_rx_s};
            r_perr <= w_perr_nxt;
        end
    end
    assign bus.parity_error = r_perr;
`else
    assign bus.parity_error = 1'b0;
`endif

    assign bus.uart_data       = r_data;
    assign bus.uart_data_valid = r_valid;
    assign bus.framing_error   = r_ferr;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: serial line driver, byte scoreboard, strobe monitor.
module tb_uart_rx_byte;
    localparam int CPB = 434;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;
    int         cyc;
    int         n_pass;
    int         n_total;
    int         valid_cnt;
    int         ferr_cnt;
    int         perr_cnt;
    int         last_valid_cyc;
    int         prev_valid_cyc;
    logic [7:0] exp_q[$];

    uart_rx_byte_if bus();

    uart_rx_byte dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic drive_bit(input logic b);
        bus.uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`else
        if (par_b === 1'bx) drive_bit(1'b1);
`endif
        drive_bit(stop_b);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, ^d, 1'b1);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.uart_data_valid || bus.framing_error || bus.parity_error)
                chk("strobe_exclusive",
                    32'(bus.uart_data_valid) + 32'(bus.framing_error) + 32'(bus.parity_error), 1);
            if (bus.uart_data_valid) begin
                valid_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("data", bus.uart_data, exp_q.pop_front());
            end
            if (bus.framing_error) ferr_cnt++;
            if (bus.parity_error)  perr_cnt++;
        end
    end

    initial begin
        n_pass = 0; n_total = 0; valid_cnt = 0; ferr_cnt = 0; perr_cnt = 0;
        last_valid_cyc = 0; prev_valid_cyc = 0;
        bus.uart_rx = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data", bus.uart_data, 8'h00);
        chk("rst_valid", bus.uart_data_valid, 0);
        chk("rst_ferr", bus.framing_error, 0);
        chk("rst_perr", bus.parity_error, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        idle(20);

        // single byte
        send_good(8'hF1);
        idle(2 * CPB);
        chk("f1_valid_cnt", valid_cnt, 1);
        chk("f1_ferr_cnt", ferr_cnt, 0);
        chk("f1_perr_cnt", perr_cnt, 0);

        // back-to-back
        send_good(8'hF2);
        send_good(8'h07);
        idle(2 * CPB);
        chk("b2b_valid_cnt", valid_cnt, 3);
        chk("b2b_spacing", last_valid_cyc - prev_valid_cyc,
`ifdef UART_RX_PARITY_EN
            11 * CPB
`else
            10 * CPB
`endif
        );

        // start glitch
        bus.uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(CPB);
        chk("glitch_state", dbg_state, 0);
        chk("glitch_valid_cnt", valid_cnt, 3);
        chk("glitch_ferr_cnt", ferr_cnt, 0);
        send_good(8'hF0);
        idle(2 * CPB);
        chk("f0_valid_cnt", valid_cnt, 4);

        // framing error then held-low line
        send_frame(8'h55, ^8'h55, 1'b0);
        repeat (2000) @(negedge clk);
        chk("ferr_cnt", ferr_cnt, 1);
        chk("ferr_state_wait_high", dbg_state, 5);
        chk("ferr_data_hold", bus.uart_data, 8'hF0);
        chk("ferr_valid_cnt", valid_cnt, 4);
        idle(CPB);
        chk("ferr_recover_state", dbg_state, 0);
        send_good(8'hF3);
        idle(2 * CPB);
        chk("f3_valid_cnt", valid_cnt, 5);

        // reset during data bit 4 of A5
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'hA5 >> i & 8'h01 ? 1'b1 : 1'b0);
        bus.uart_rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_data", bus.uart_data, 8'h00);
        chk("midrst_valid", bus.uart_data_valid, 0);
        chk("midrst_ferr", bus.framing_error, 0);
        chk("midrst_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2 * CPB);
        chk("midrst_valid_cnt", valid_cnt, 5);
        chk("midrst_ferr_cnt", ferr_cnt, 1);
        send_good(8'h09);
        idle(2 * CPB);
        chk("09_valid_cnt", valid_cnt, 6);

        // random back-to-back bytes
        for (int i = 0; i < 2; i++) send_good(8'($urandom_range(0, 255)));
        idle(2 * CPB);
        chk("rand_valid_cnt", valid_cnt, 8);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("par_bad_perr_cnt", perr_cnt, 1);
        chk("par_bad_valid_cnt", valid_cnt, 8);
        chk("par_bad_ferr_cnt", ferr_cnt, 1);
        send_good(8'h03);
        idle(2 * CPB);
        chk("par_good_valid_cnt", valid_cnt, 9);
        chk("par_good_perr_cnt", perr_cnt, 1);
`else
        chk("noparity_perr_cnt", perr_cnt, 0);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial UART receiver for the Cyclone V starter-kit LED path: oversamples the board RX pin, de-frames 8N1 characters (optionally 8E1) and delivers each good byte as `uart_data` with a one-cycle `uart_data_valid` strobe. It sits directly upstream of the seven-segment LED control stage, which consumes those two signals. Bad frames are flagged and never strobed downstream.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `CLKS_PER_BIT`: derived as round(CLK_FREQ/BAUD_RATE), which is 434 at defaults. `HALF_BIT` is CLKS_PER_BIT/2, truncated. Elaboration `$error` if CLKS_PER_BIT < 4.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: asynchronous serial line; idles high.
- `uart_data` out 8: last correctly received byte.
- `uart_data_valid` out 1: one-cycle strobe for a new `uart_data`.
- `framing_error` out 1: one-cycle strobe when the stop bit is sampled low.
- `parity_error` out 1: one-cycle strobe on parity mismatch. Constant 0 when parity is compiled out.

## Operation
- Input synchronizer:
  - `uart_rx` passes through a 2-flop synchronizer; its flops reset to 1. The synchronized value is `rx_s`.
  - Start detection uses `rx_s` and a third registered copy (falling edge = previous 1, current 0).
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
  - IDLE: falling edge on `rx_s` → START, bit counter cleared.
  - START: when the counter reaches HALF_BIT-1, sample `rx_s`. If 0 → DATA with counter cleared. If 1, the start was a glitch → IDLE with no output.
  - DATA: sample at counter = CLKS_PER_BIT-1, giving mid-bit timing. Bits shift in LSB first. After 8 bits → PARITY if compiled in, else STOP.
  - PARITY: sample the parity bit at CLKS_PER_BIT-1 and store the mismatch flag → STOP.
  - STOP, sampled at CLKS_PER_BIT-1, with three outcomes:
    - `rx_s`=1 and no parity mismatch: load `uart_data` from the shift register, pulse `uart_data_valid` → IDLE.
    - `rx_s`=1 with a parity mismatch: pulse `parity_error` only → IDLE.
    - `rx_s`=0: pulse `framing_error`, which takes precedence over the parity error → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then → IDLE. This covers breaks and a held-low line.
- Counter width: $clog2(CLKS_PER_BIT). The counter is cleared on every state transition and never wraps mid-bit.
- `uart_data` changes only on a good frame. It holds its value across error frames and glitches.
- Strobes are mutually exclusive: at most one of valid, framing_error and parity_error is high in any cycle.

## Timing
- Reset values: `uart_data`=8'h00, `uart_data_valid`=0, `framing_error`=0, `parity_error`=0. State = IDLE, synchronizer = 1.
- Reset asserted mid-frame aborts immediately with no strobe. After release the receiver waits for a fresh falling edge.
- Latency from the `uart_rx` falling edge to the strobe:
  - 2 synchronizer cycles + 1 edge-detect cycle + (HALF_BIT + 9×CLKS_PER_BIT) sample-point cycles + 1 output register cycle.
  - With parity, add CLKS_PER_BIT.
- Strobes are registered and exactly one clk wide.
- Back-to-back frames: STOP goes directly to IDLE at the mid-stop sample, so a start edge half a bit later is caught. Continuous traffic at full rate loses nothing.
- There is no backpressure. The downstream stage must accept one strobe per frame, i.e. at least 10×CLKS_PER_BIT cycles apart.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1: start, 8 data bits, an even-parity bit (XOR of the data bits and the parity bit must be 0), stop.
  - PARITY state is present and `parity_error` is live.
- Undefined:
  - Frame is 8N1 and the PARITY state is not generated.
  - `parity_error` is tied to 0.

## Test plan
All cases use defaults (434 clk/bit), a bit-accurate serial driver and reset deasserted before stimulus.
- Send 8'hF1 → exactly one `uart_data_valid` pulse, `uart_data`=8'hF1, both error outputs stay 0.
- Send 8'hF2 then 8'h07 back-to-back with no idle gap → two valid pulses 4340 clks apart, data F2 then 07.
- Drive `uart_rx` low for 100 clks then high → no strobe of any kind, FSM back in IDLE; a following 8'hF0 is received correctly.
- Send 8'h55 with stop bit=0, then hold the line low for 2000 clks, then send 8'hF3:
  - one `framing_error` pulse, no valid pulse, `uart_data` keeps its previous value;
  - 8'hF3 is then received correctly.
- Assert `reset` during data bit 4 of 8'hA5 → all outputs are 0 within the same cycle, no strobe; the next 8'h09 is received.
- With `UART_RX_PARITY_EN`, send 8'h03 with parity bit 1 → one `parity_error` pulse, no valid pulse. The same byte with parity bit 0 gives a valid pulse with `uart_data`=8'h03.
